// File: rtl/sipo_rx_controller.sv
// Serial receive controller: frames start/data/parity/stop bits from a sampled line
// and delivers each frame through a valid/ready handshake, flagging parity, framing and overrun errors.
module sipo_rx_controller #(
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_tick,
    input  logic                 serial_in,
    input  logic                 rx_ready,
    output logic                 shift,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DATA   = 3'd1;
    localparam logic [2:0] PARITY = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] BREAK  = 3'd4;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_fail_q, par_fail_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_fail_d   = par_fail_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;

        // Consumption first; a good stop bit below may re-assert valid at the same edge.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bit_tick && !serial_in) begin
                    state_d    = DATA;
                    bit_cnt_d  = '0;
                    par_fail_d = 1'b0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_d   = {shreg_q[DATA_BITS-2:0], serial_in};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    par_fail_d = (^shreg_q) ^ serial_in;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (serial_in) begin
                        parity_err_d = par_fail_q;
                        state_d      = IDLE;
                        if (rx_valid_q && !rx_ready) begin
                            overrun_d = 1'b1;
                        end else begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (bit_tick && serial_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_fail_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_fail_q   <= par_fail_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign shift      = (state_q == DATA) && bit_tick;
    assign busy       = (state_q != IDLE);
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
